// File: rtl/apb_master_mux.sv
// apb_master_mux: APB4 requester with address-decoded PSEL, back-to-back transfers and wait-state timeout
module apb_master_mux #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic [DATA_W/8-1:0]         req_strb,
  input  logic [2:0]                  req_prot,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        rsp_tmo,
  output logic [ADDR_W-1:0]           PADDR,
  output logic [2:0]                  PPROT,
  output logic [NUM_SLV-1:0]          PSEL,
  output logic                        PENABLE,
  output logic                        PWRITE,
  output logic [DATA_W-1:0]           PWDATA,
  output logic [DATA_W/8-1:0]         PSTRB,
  input  logic [NUM_SLV-1:0]          PREADY,
  input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]          PSLVERR,
  output logic [1:0]                  state_o
);
  localparam int SW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] sel, req_idx;
  logic [31:0] cnt;
  logic rdy, abort, acc, good, fin, derr, pend;
  assign req_idx = req_addr[SEL_LSB +: SW];
  assign good    = 32'(req_idx) < NUM_SLV;
  assign rdy     = PREADY[sel];
  assign acc     = req_valid & req_ready;
  assign derr    = acc & ~good;
  assign abort   = (TIMEOUT != 0) && state == ACCESS && !rdy && cnt == TIMEOUT;
  assign fin     = state == ACCESS && (rdy || abort);
  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else state <= state_nxt;
  end
  // Next state: a completing ACCESS behaves like IDLE so a new request can chain straight into SETUP
  always_comb begin
    state_nxt = state == SETUP ? ACCESS :
                (state == IDLE || (state == ACCESS && rdy)) ? ((acc && good) ? SETUP : IDLE) :
                (state == ACCESS && !abort) ? ACCESS : IDLE;
  end
  // Bus control outputs decoded from state and the latched slave index
  always_comb begin
    req_ready = state == IDLE || (state == ACCESS && rdy);
    PENABLE   = state == ACCESS;
    PSEL      = (state == SETUP || state == ACCESS) ? NUM_SLV'(1'b1) << sel : '0;
    state_o   = state;
  end
  // Request fields captured on accept and held for the whole transfer
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR  <= '0;
      PPROT  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
      sel    <= '0;
    end else if (acc) begin
      PADDR  <= req_addr;
      PPROT  <= req_prot;
      PWRITE <= req_write;
      PWDATA <= req_wdata;
      PSTRB  <= req_write ? req_strb : '0;
      sel    <= req_idx;
    end
  end
  // Wait-state counter, cleared while entering ACCESS
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt <= '0;
    else if (state == SETUP) cnt <= '0;
    else if (state == ACCESS && !rdy) cnt <= cnt + 32'd1;
  end
  // Response: a decode error accepted while a transfer completes is deferred one slot to keep order
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
      pend      <= 1'b0;
    end else begin
      rsp_valid <= fin | pend | derr;
      pend      <= (fin | pend) & derr;
      if (fin) begin
        rsp_err   <= abort | PSLVERR[sel];
        rsp_tmo   <= abort;
        rsp_rdata <= (abort | PWRITE | PSLVERR[sel]) ? '0 : PRDATA[32'(sel)*DATA_W +: DATA_W];
      end else if (pend | derr) begin
        rsp_err   <= 1'b1;
        rsp_tmo   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_mux.sv
// tb_apb_master_mux: directed tests with a response-queue model and bench-side APB slaves
module tb_apb_master_mux;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;
  logic req_valid, req_ready, req_write, rsp_valid, rsp_err, rsp_tmo, penable, pwrite;
  logic [31:0] req_addr, req_wdata, rsp_rdata, paddr, pwdata;
  logic [3:0] req_strb, pstrb, psel, pready, pslverr;
  logic [2:0] req_prot, pprot;
  logic [127:0] prdata;
  logic [1:0] state_o;
  logic d_valid, d_ready, d_rsp_valid, d_err, d_tmo, d_penable, d_pwrite;
  logic [31:0] d_addr, d_rdata, d_paddr, d_pwdata;
  logic [3:0] d_pstrb;
  logic [2:0] d_pprot, d_psel;
  logic [1:0] d_state;

  apb_master_mux #(.NUM_SLV(4), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_tmo(rsp_tmo), .PADDR(paddr), .PPROT(pprot), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready), .PRDATA(prdata),
    .PSLVERR(pslverr), .state_o(state_o));

  apb_master_mux #(.NUM_SLV(3), .TIMEOUT(4)) u3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(d_valid), .req_ready(d_ready),
    .req_write(1'b0), .req_addr(d_addr), .req_wdata(32'h0), .req_strb(4'h0),
    .req_prot(3'h0), .rsp_valid(d_rsp_valid), .rsp_rdata(d_rdata), .rsp_err(d_err),
    .rsp_tmo(d_tmo), .PADDR(d_paddr), .PPROT(d_pprot), .PSEL(d_psel), .PENABLE(d_penable),
    .PWRITE(d_pwrite), .PWDATA(d_pwdata), .PSTRB(d_pstrb), .PREADY(3'b111), .PRDATA(96'h0),
    .PSLVERR(3'b000), .state_o(d_state));

  typedef struct {logic [31:0] rdata; logic err; logic tmo;} rsp_t;
  rsp_t exp_q[$];
  rsp_t e;
  int wait_cfg[4];
  logic [31:0] rd_cfg[4];
  logic err_cfg[4];
  int wcnt;
  int checks = 0;
  int passes = 0;
  int en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Slave i holds PREADY low for wait_cfg[i] ACCESS cycles
  always_comb begin
    pready = '0;
    prdata = '0;
    pslverr = '0;
    for (int i = 0; i < 4; i++) begin
      pready[i] = wcnt >= wait_cfg[i];
      prdata[i*32 +: 32] = rd_cfg[i];
      pslverr[i] = err_cfg[i];
    end
  end

  // Count ACCESS cycles spent waiting
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wcnt <= 0;
    else wcnt <= (penable && (pready & psel) == 4'h0) ? wcnt + 1 : 0;
  end

  // Expected response from slave configuration: more waits than TIMEOUT means abort
  function automatic rsp_t model(input logic w, input logic [31:0] a);
    rsp_t r;
    int i;
    i = int'(a[13:12]);
    if (wait_cfg[i] > 4) r = '{32'h0, 1'b1, 1'b1};
    else if (err_cfg[i]) r = '{32'h0, 1'b1, 1'b0};
    else r = '{w ? 32'h0 : rd_cfg[i], 1'b0, 1'b0};
    return r;
  endfunction

  logic prev_en, prev_rdy, prev_write;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0] prev_sel;

  // Per-cycle compare against the model and APB protocol rules
  always @(negedge PCLK) begin
    if (!PRESETn) prev_en <= 1'b0;
    else begin
      if (rsp_valid) begin
        chk("rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_tmo", rsp_tmo, e.tmo);
        end
      end
      chk("psel_onehot0", $countones(psel) <= 1, 1);
      if (penable) chk("penable_onehot", $countones(psel), 1);
      if (|psel && !pwrite) chk("pstrb_read", pstrb, 0);
      if (penable && prev_en && !prev_rdy) begin
        chk("hold_addr", paddr, prev_addr);
        chk("hold_sel", psel, prev_sel);
        chk("hold_wdata", pwdata, prev_wdata);
        chk("hold_write", pwrite, prev_write);
      end
      prev_en <= penable;
      prev_rdy <= |(pready & psel);
      prev_addr <= paddr;
      prev_sel <= psel;
      prev_wdata <= pwdata;
      prev_write <= pwrite;
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p, input bit hold);
    int n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    req_strb = s;
    req_prot = p;
    while (!req_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    chk("accept_wait", n < 50, 1);
    exp_q.push_back(model(w, a));
    @(posedge PCLK);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    int n = 0;
    cyc = 0;
    do begin
      @(negedge PCLK);
      n++;
      if (penable) cyc++;
    end while (!rsp_valid && n < 40);
    chk("rsp_arrives", rsp_valid, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      wait_cfg[i] = 0;
      rd_cfg[i] = 32'hA0 + 32'(i);
      err_cfg[i] = 1'b0;
    end
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0; req_prot = 0;
    d_valid = 0; d_addr = 0;
    #2;
    chk("rst_state", state_o, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    send(1'b1, 32'h0000_1004, 32'hDEADBEEF, 4'h3, 3'b010, 1'b0);
    @(negedge PCLK);
    chk("t1_setup_psel", psel, 4'b0010);
    chk("t1_setup_penable", penable, 0);
    chk("t1_pstrb", pstrb, 4'h3);
    chk("t1_paddr", paddr, 32'h1004);
    chk("t1_pwdata", pwdata, 32'hDEADBEEF);
    chk("t1_pprot", pprot, 3'b010);
    @(negedge PCLK);
    chk("t1_access_psel", psel, 4'b0010);
    chk("t1_access_penable", penable, 1);
    @(negedge PCLK);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_rdata", rsp_rdata, 0);
    chk("t1_idle_psel", psel, 0);

    wait_cfg[2] = 2; rd_cfg[2] = 32'h12345678;
    send(1'b0, 32'h0000_2008, 32'h0, 4'hF, 3'b000, 1'b0);
    wait_rsp(en);
    chk("t2_access_cycles", en, 3);
    chk("t2_rdata", rsp_rdata, 32'h12345678);
    chk("t2_err", rsp_err, 0);
    chk("t2_pstrb", pstrb, 0);

    wait_cfg[0] = 1; err_cfg[0] = 1'b1;
    send(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b001, 1'b0);
    wait_rsp(en);
    chk("t3_err", rsp_err, 1);
    chk("t3_tmo", rsp_tmo, 0);
    chk("t3_rdata", rsp_rdata, 0);
    err_cfg[0] = 1'b0; wait_cfg[0] = 0;

    wait_cfg[2] = 255;
    send(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b000, 1'b0);
    wait_rsp(en);
    chk("t4_access_cycles", en, 5);
    chk("t4_err", rsp_err, 1);
    chk("t4_tmo", rsp_tmo, 1);
    chk("t4_rdata", rsp_rdata, 0);
    chk("t4_psel", psel, 0);
    wait_cfg[2] = 0;
    send(1'b1, 32'h0000_1000, 32'h55, 4'hF, 3'b000, 1'b0);
    wait_rsp(en);
    chk("t4_next_err", rsp_err, 0);
    chk("t4_next_tmo", rsp_tmo, 0);

    wait_cfg[3] = 4;
    send(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'b000, 1'b0);
    wait_rsp(en);
    chk("t4b_access_cycles", en, 5);
    chk("t4b_tmo", rsp_tmo, 0);
    chk("t4b_rdata", rsp_rdata, 32'hA3);
    wait_cfg[3] = 0;

    send(1'b1, 32'h0000_0000, 32'h11, 4'hF, 3'b000, 1'b1);
    @(negedge PCLK);
    chk("t5_psel0", psel, 4'b0001);
    chk("t5_penable0", penable, 0);
    send(1'b1, 32'h0000_3000, 32'h33, 4'hF, 3'b000, 1'b0);
    @(negedge PCLK);
    chk("t5_psel3", psel, 4'b1000);
    chk("t5_penable3", penable, 0);
    chk("t5_rsp1", rsp_valid, 1);
    wait_rsp(en);
    chk("t5_rsp2_err", rsp_err, 0);
    send(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000, 1'b1);
    send(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b000, 1'b0);
    wait_rsp(en);
    chk("t5_rd1", rsp_rdata, 32'hA1);
    wait_rsp(en);
    chk("t5_rd2", rsp_rdata, 32'h12345678);

    d_valid = 1'b1; d_addr = 32'h0000_3000;
    chk("t6_ready", d_ready, 1);
    @(posedge PCLK);
    #1 d_valid = 1'b0;
    @(negedge PCLK);
    chk("t6_psel", d_psel, 0);
    chk("t6_rsp_valid", d_rsp_valid, 1);
    chk("t6_err", d_err, 1);
    chk("t6_tmo", d_tmo, 0);
    chk("t6_rdata", d_rdata, 0);
    chk("t6_state", d_state, 0);
    @(negedge PCLK);
    chk("t6_pulse", d_rsp_valid, 0);

    wait_cfg[1] = 255;
    send(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000, 1'b0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("t7_in_access", penable, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("t7_psel_drop", psel, 0);
    chk("t7_penable_drop", penable, 0);
    exp_q.delete();
    @(negedge PCLK);
    PRESETn = 1'b1;
    wait_cfg[1] = 0;
    repeat (3) begin
      @(negedge PCLK);
      chk("t7_no_rsp", rsp_valid, 0);
    end
    chk("t7_state", state_o, 0);

    for (int n = 0; n < 100 && exp_q.size() > 0; n++) @(negedge PCLK);
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
